// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared defaults and destination encoding for stream_demux2
package stream_demux_pkg;
    localparam int DEFAULT_DW   = 8;
    localparam int DEFAULT_CNTW = 16;

    typedef enum logic {
        DEST_B = 1'b0,
        DEST_A = 1'b1
    } dest_e;
endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry output register slot with handshake counter
module demux_out_slot
    import stream_demux_pkg::*;
#(
    parameter int DW   = DEFAULT_DW,
    parameter int CNTW = DEFAULT_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fill,
    input  logic [DW-1:0]   fill_data,
    input  logic            ready,
    output logic            valid,
    output logic [DW-1:0]   data,
    output logic [CNTW-1:0] count,
    output logic            slot_free
);
    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            drain;

    assign drain     = valid_q & ready;
    assign slot_free = ~valid_q | ready;

    // A fill in the same cycle as a drain wins, keeping the slot full at one beat per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (drain) begin
            valid_d = 1'b0;
            count_d = count_q + CNTW'(1);
        end
        if (fill) begin
            valid_d = 1'b1;
            data_d  = fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign count = count_q;
endmodule

// File: rtl/stream_demux2.sv
// rtl/stream_demux2.sv - registered 1:2 stream demux; DEMUX_ASSERT_EN adds a protocol checker
module stream_demux2
    import stream_demux_pkg::*;
#(
    parameter int DW   = DEFAULT_DW,
    parameter int CNTW = DEFAULT_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sel,
    input  logic [DW-1:0]   in_data,
    output logic            a_valid,
    input  logic            a_ready,
    output logic [DW-1:0]   a_data,
    output logic [CNTW-1:0] a_count,
    output logic            b_valid,
    input  logic            b_ready,
    output logic [DW-1:0]   b_data,
    output logic [CNTW-1:0] b_count
);
    dest_e in_dest;
    logic  a_free, b_free;
    logic  accept;
    logic  fill_a, fill_b;

    assign in_dest = dest_e'(in_sel);
    // Only the selected slot gates the input, so a stalled target blocks both channels.
    assign in_ready = (in_dest == DEST_A) ? a_free : b_free;
    assign accept   = in_valid & in_ready;
    assign fill_a   = accept & (in_dest == DEST_A);
    assign fill_b   = accept & (in_dest == DEST_B);

    demux_out_slot #(.DW(DW), .CNTW(CNTW)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .fill      (fill_a),
        .fill_data (in_data),
        .ready     (a_ready),
        .valid     (a_valid),
        .data      (a_data),
        .count     (a_count),
        .slot_free (a_free)
    );

    demux_out_slot #(.DW(DW), .CNTW(CNTW)) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .fill      (fill_b),
        .fill_data (in_data),
        .ready     (b_ready),
        .valid     (b_valid),
        .data      (b_data),
        .count     (b_count),
        .slot_free (b_free)
    );

`ifdef DEMUX_ASSERT_EN
    logic            prev_ok;
    logic            prev_a_stall, prev_b_stall, prev_in_stall, prev_in_sel;
    logic            prev_a_hs, prev_b_hs;
    logic [DW-1:0]   prev_a_data, prev_b_data, prev_in_data;
    logic [CNTW-1:0] prev_a_count, prev_b_count;

    always @(posedge clk) begin
        if (!rst) begin
            if ($isunknown({in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count}))
                $error("stream_demux2: output is X/Z out of reset");
            if (prev_ok) begin
                if (prev_a_stall && (!a_valid || a_data != prev_a_data))
                    $error("stream_demux2: A changed while stalled");
                if (prev_b_stall && (!b_valid || b_data != prev_b_data))
                    $error("stream_demux2: B changed while stalled");
                if (prev_in_stall && (!in_valid || in_data != prev_in_data || in_sel != prev_in_sel))
                    $error("stream_demux2: upstream changed while stalled");
                if (a_count != prev_a_count + CNTW'(prev_a_hs))
                    $error("stream_demux2: a_count step wrong");
                if (b_count != prev_b_count + CNTW'(prev_b_hs))
                    $error("stream_demux2: b_count step wrong");
            end
        end
        prev_ok       <= !rst;
        prev_a_stall  <= a_valid & ~a_ready;
        prev_b_stall  <= b_valid & ~b_ready;
        prev_in_stall <= in_valid & ~in_ready;
        prev_in_sel   <= in_sel;
        prev_in_data  <= in_data;
        prev_a_hs     <= a_valid & a_ready;
        prev_b_hs     <= b_valid & b_ready;
        prev_a_data   <= a_data;
        prev_b_data   <= b_data;
        prev_a_count  <= a_count;
        prev_b_count  <= b_count;
    end
`endif
endmodule

// File: tb/tb_stream_demux2.sv
// tb/tb_stream_demux2.sv - scoreboard bench for stream_demux2
module tb_stream_demux2;
    localparam int DW   = 8;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sel = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            a_valid, b_valid;
    logic            a_ready = 1'b1;
    logic            b_ready = 1'b1;
    logic [DW-1:0]   a_data, b_data;
    logic [CNTW-1:0] a_count, b_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];

    stream_demux2 #(.DW(DW), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected beat of its channel.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected: got beat 0x%0h, expected none", a_data);
                end else chk("a_data", a_data, qa.pop_front());
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got beat 0x%0h, expected none", b_data);
                end else chk("b_data", b_data, qb.pop_front());
            end
        end
    end

    task automatic send(input logic sel, input logic [DW-1:0] d);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (sel) qa.push_back(d);
                else     qb.push_back(d);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat 0x%0h not accepted, expected accept within 50 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_b_count", b_count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Routing with one-cycle latency
        send(1'b1, 8'h11);
        chk("route_a_valid", a_valid, 1);
        chk("route_a_data", a_data, 8'h11);
        send(1'b0, 8'h22);
        chk("route_b_valid", b_valid, 1);
        chk("route_b_data", b_data, 8'h22);
        idle(2);
        chk("route_a_count", a_count, 1);
        chk("route_b_count", b_count, 1);

        // Stall and hold; head-of-line only on the selected target
        a_ready = 1'b0;
        send(1'b1, 8'h5A);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h6B;
        repeat (2) begin @(posedge clk); #1; end
        chk("stall_in_ready", in_ready, 0);
        chk("stall_a_valid", a_valid, 1);
        chk("stall_a_data", a_data, 8'h5A);
        in_valid = 1'b0; in_sel = 1'b0;
        #1;
        chk("stall_other_ready", in_ready, 1);
        a_ready = 1'b1;
        send(1'b1, 8'h6B);
        idle(2);
        chk("stall_a_count", a_count, 3);
        chk("stall_b_count", b_count, 1);

        // Full throughput on A
        do_reset(1);
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) send(1'b1, 8'(i));
        chk("tput_cycles", cyc - start_cyc, 8);
        idle(2);
        chk("tput_a_count", a_count, 8);
        chk("tput_b_count", b_count, 0);

        // Counter wrap at 2^CNTW
        do_reset(1);
        for (int i = 0; i < 17; i++) send(1'b0, 8'(8'h80 + i));
        idle(2);
        chk("wrap_b_count", b_count, 1);
        chk("wrap_a_count", a_count, 0);

        // Reset while A is stalled: the held beat is dropped
        do_reset(1);
        send(1'b1, 8'h01);
        send(1'b1, 8'h02);
        idle(2);
        chk("mid_pre_count", a_count, 2);
        a_ready = 1'b0;
        send(1'b1, 8'hC3);
        in_valid = 1'b0;
        chk("mid_held_valid", a_valid, 1);
        chk("mid_held_data", a_data, 8'hC3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_a_valid", a_valid, 0);
        chk("mid_rst_a_count", a_count, 0);
        rst = 1'b0;
        qa.delete();
        a_ready = 1'b1;
        idle(4);
        chk("mid_post_a_valid", a_valid, 0);
        chk("mid_post_a_count", a_count, 0);

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
